// File: rtl/sect163r1_pt_mul_arb.sv
// Round-robin arbiter/sequencer sharing one sect163r1 point multiplier between NUM_REQ clients.
// Grants a requester, runs the multiplier under a watchdog and returns x/y tagged with the client id.
module sect163r1_pt_mul_arb #(
    parameter int M       = 163,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 1048575,
    parameter int TO_W    = 20
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ*M-1:0] req_d_i,
    output logic [NUM_REQ-1:0]   req_ack_o,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [ID_W-1:0]      rsp_id_o,
    output logic [M-1:0]         rsp_x_o,
    output logic [M-1:0]         rsp_y_o,
    output logic                 rsp_err_o,
    output logic                 mul_clr_o,
    output logic                 mul_start_o,
    output logic [M-1:0]         mul_d_o,
    input  logic                 mul_done_i,
    input  logic [M-1:0]         mul_x_i,
    input  logic [M-1:0]         mul_y_i,
    output logic                 busy_o,
    output logic [2:0]           dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BUSY  = 3'd2,
        S_RESP  = 3'd3,
        S_ABORT = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [M-1:0]         mul_d_q, mul_d_d;
    logic [TO_W-1:0]      wd_q, wd_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [M-1:0]         rsp_x_q, rsp_x_d;
    logic [M-1:0]         rsp_y_q, rsp_y_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 start_q, start_d;
    logic                 clr_q, clr_d;

    logic                 gnt_found;
    logic [ID_W-1:0]      gnt_id;
    logic [ID_W-1:0]      gnt_next_ptr;
    logic [M-1:0]         gnt_scalar;
    int                   gnt_idx;

    // First set request at or above the pointer, wrapping; the pointer makes the last winner lowest priority.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        gnt_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            gnt_idx = int'(ptr_q) + k;
            if (gnt_idx >= NUM_REQ) begin
                gnt_idx = gnt_idx - NUM_REQ;
            end
            if (!gnt_found && req_i[gnt_idx[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = gnt_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_scalar = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_id == ID_W'(k)) begin
                gnt_scalar = req_d_i[k*M +: M];
            end
        end
        gnt_next_ptr = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    end

    // Response channel: a beat transfers on any edge with rsp_valid_o && rsp_ready_i; while valid is
    // high and ready is low every rsp_* output is held, and valid never drops without a transfer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        mul_d_d     = mul_d_q;
        wd_d        = wd_q;
        rsp_valid_d = rsp_valid_q;
        rsp_x_d     = rsp_x_q;
        rsp_y_d     = rsp_y_q;
        rsp_err_d   = rsp_err_q;
        ack_d       = '0;
        start_d     = 1'b0;
        clr_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    ack_d   = NUM_REQ'(1) << gnt_id;
                    mul_d_d = gnt_scalar;
                    id_d    = gnt_id;
                    ptr_d   = gnt_next_ptr;
                    state_d = S_START;
                end
            end
            S_START: begin
                start_d = 1'b1;
                wd_d    = '0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                // done is tested first so a completion on the last watchdog cycle still counts.
                if (mul_done_i) begin
                    rsp_x_d     = mul_x_i;
                    rsp_y_d     = mul_y_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
                    rsp_x_d   = '0;
                    rsp_y_d   = '0;
                    rsp_err_d = 1'b1;
                    clr_d     = 1'b1;
                    state_d   = S_ABORT;
                end else begin
                    wd_d = wd_q + TO_W'(1);
                end
            end
            S_ABORT: begin
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_valid_q && rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            mul_d_q     <= '0;
            wd_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_x_q     <= '0;
            rsp_y_q     <= '0;
            rsp_err_q   <= 1'b0;
            ack_q       <= '0;
            start_q     <= 1'b0;
            clr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            mul_d_q     <= mul_d_d;
            wd_q        <= wd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_x_q     <= rsp_x_d;
            rsp_y_q     <= rsp_y_d;
            rsp_err_q   <= rsp_err_d;
            ack_q       <= ack_d;
            start_q     <= start_d;
            clr_q       <= clr_d;
        end
    end

    assign req_ack_o   = ack_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = id_q;
    assign rsp_x_o     = rsp_x_q;
    assign rsp_y_o     = rsp_y_q;
    assign rsp_err_o   = rsp_err_q;
    assign mul_clr_o   = clr_q;
    assign mul_start_o = start_q;
    assign mul_d_o     = mul_d_q;
    assign busy_o      = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: doc/sect163r1_pt_mul_arb.md
Name: sect163r1_pt_mul_arb

Overview:
- Round-robin arbiter and sequencer that shares one sect163r1 point-multiplier instance between NUM_REQ requesters.
- Grants one requester, latches its scalar and pulses the multiplier start.
- Waits for done with a watchdog, then returns x/y tagged with the requester id over a valid/ready response channel.
- Sits between the client blocks (e.g. key-generation and ECDH engines) and the point-multiplier core.

Parameters:
- M, 163, field degree / scalar and coordinate width
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester id width; must equal clog2(NUM_REQ)
- TIMEOUT, 1048575, maximum cycles from mul_start to mul_done before abort
- TO_W, 20, watchdog counter width; TIMEOUT must fit

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req  in  NUM_REQ  per-requester request level; held until ack
- req_d  in  NUM_REQ*M  scalars; requester i occupies bits [i*M +: M]
- req_ack  out  NUM_REQ  one-hot, one-cycle pulse: request accepted, scalar captured
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_W  index of the served requester
- rsp_x  out  M  result x coordinate (zero on error)
- rsp_y  out  M  result y coordinate (zero on error)
- rsp_err  out  1  watchdog abort for this response
- mul_clr  out  1  synchronous clear to the multiplier
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_d  out  M  scalar to the multiplier; stable from mul_start until done or abort
- mul_done  in  1  one-cycle pulse; mul_x/mul_y valid in the same cycle
- mul_x  in  M  multiplier x output
- mul_y  in  M  multiplier y output
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0. State IDLE. Round-robin pointer set to 0, so requester 0 has highest priority first. Watchdog count 0.
- FSM states: IDLE, START, BUSY, RESP, ABORT.
- IDLE:
  - If any req bit is set, grant the first set bit searching upward from the pointer, with wrap-around.
  - Same edge: capture req_d slice into mul_d, capture id, pulse req_ack[id] for one cycle, advance pointer to id+1 mod NUM_REQ. Go to START.
- START:
  - mul_start=1 for exactly one cycle; watchdog cleared to 0. Go to BUSY.
- BUSY:
  - Watchdog increments each cycle.
  - mul_done=1: capture mul_x/mul_y into rsp_x/rsp_y, rsp_err=0, rsp_valid=1. Go to RESP.
  - Watchdog reaches TIMEOUT-1 without done: rsp_x=rsp_y=0, rsp_err=1. Go to ABORT.
  - If done and timeout coincide, done wins.
- ABORT:
  - mul_clr=1 for exactly one cycle, rsp_valid=1. Go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid=1 && rsp_ready=0.
  - On rsp_valid && rsp_ready: drop rsp_valid next cycle and go to IDLE.
  - No new grant in the handshake cycle. Minimum request-to-request spacing is the latency plus 1 cycle.
- Latency: req seen in IDLE, then ack at edge 1, mul_start in cycle 2, result valid 1 cycle after mul_done.
- mul_done outside BUSY is ignored. req changes outside IDLE are ignored; the granted scalar is already captured.
- A requester deasserting req before ack simply loses its slot; it is never acked.
- Reset mid-operation: return immediately to reset values and do not pulse mul_clr. The core is expected to share rst via its own reset.
- Fairness: a requester continuously asserting req waits at most NUM_REQ-1 services.

Test Plan:
- Single request: req=4'b0001, req_d[0]=1, mul model returns done after 10 cycles with x=XG, y=YG. Expect:
  - ack[0] pulse, mul_start one cycle later, mul_d=1;
  - rsp_valid with id=0, x=XG, y=YG, err=0;
  - busy low after the rsp_ready handshake.
- Round robin: req=4'b1111 held, each d=i+2. Expect grants in order 0,1,2,3,0, each rsp_id matching, and mul_d=i+2 at each start.
- Backpressure: rsp_ready=0 for 20 cycles after valid. Expect rsp_* stable, no new ack, no mul_start; on ready=1, exactly one transfer, then the next grant.
- Watchdog: TIMEOUT=64 and the model never pulses done. Expect mul_clr pulse at cycle 64 after start, rsp_err=1 with x=y=0, then normal service of the next request.
- Boundaries:
  - mul_done arriving on the same cycle as timeout: expect err=0 and the real x/y.
  - Spurious mul_done in IDLE: expect no response.
- Reset: assert rst during BUSY. Expect all outputs 0 asynchronously, pointer back to 0, and the first grant after release going to requester 0 with req=4'b1001.
